// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream frame FIFO.
// Each stored beat record is packed as {tlast, tuser, tkeep, tdata}; the field
// offsets below are measured from the top of the tkeep/tdata payload.
package axis_pkg;

    // Position of tlast above the payload (payload = tdata + tkeep bits).
    localparam int TLAST_BIT = 1;
    // Position of tuser above the payload.
    localparam int TUSER_BIT = 0;

    // Total width of one stored beat record.
    function automatic int rec_width(input int data_width, input int keep_width);
        return data_width + keep_width + 2;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM for the frame FIFO: one write port, one read port with
// a single registered read stage. The read register only updates on rd_en so
// it can double as the AXI-Stream output holding register.
module axis_fifo_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int WIDTH      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
    logic [WIDTH-1:0] rd_data_reg;

    // Write port: store one beat record per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered read, held while rd_en is low; cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO.
// A frame only becomes visible at the output once its tlast beat is written;
// frames that do not fit are dropped whole.
// Build option: define AXIS_FRAME_FIFO_DROP_BAD_EN to discard frames whose
// tlast beat carries tuser=1 (bad_frame pulses, output tuser is held at 0).
module axis_frame_fifo
    import axis_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);

    localparam int REC_W    = rec_width(DATA_WIDTH, KEEP_WIDTH);
    localparam int LAST_IDX = DATA_WIDTH + KEEP_WIDTH + TLAST_BIT;
    localparam int USER_IDX = DATA_WIDTH + KEEP_WIDTH + TUSER_BIT;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // wr_ptr_reg: end of committed data; wr_ptr_cur_reg: speculative write
    // position inside the frame being received; rd_ptr_reg: next beat to read.
    logic [ADDR_WIDTH:0] wr_ptr_reg;
    logic [ADDR_WIDTH:0] wr_ptr_cur_reg;
    logic [ADDR_WIDTH:0] rd_ptr_reg;
    logic                drop_frame_reg;
    logic                out_valid_reg;
    logic                overflow_reg;
    logic                good_frame_reg;

    logic                full;
    logic                empty;
    logic                accept;
    logic                wr_en;
    logic                rd_en;
    logic [REC_W-1:0]    wr_rec;
    logic [REC_W-1:0]    rd_rec;

    // Full is judged against the speculative pointer so a frame in progress
    // cannot overwrite unread data; empty only looks at committed data.
    assign full  = (wr_ptr_cur_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                   (wr_ptr_cur_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // The FIFO never back-pressures: beats that do not fit are dropped.
    assign input_axis_tready = ~rst;
    assign accept            = input_axis_tvalid & input_axis_tready;
    assign wr_en             = accept & ~full & ~drop_frame_reg;

    // tuser is only meaningful on the last beat, so it is stored only there.
    assign wr_rec = {input_axis_tlast, input_axis_tuser & input_axis_tlast,
                     input_axis_tkeep, input_axis_tdata};

    // Output register is reloaded whenever it is empty or being consumed.
    assign rd_en = ~empty & (output_axis_tready | ~out_valid_reg);

    axis_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (REC_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_cur_reg[ADDR_WIDTH-1:0]),
        .wr_data (wr_rec),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
        .rd_data (rd_rec)
    );

`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
    logic bad_frame_reg;
`endif

    // Write side: speculative writes, commit on tlast, whole-frame drop on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            wr_ptr_cur_reg <= '0;
            drop_frame_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            good_frame_reg <= 1'b0;
`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
            bad_frame_reg  <= 1'b0;
`endif
        end else begin
            overflow_reg   <= 1'b0;
            good_frame_reg <= 1'b0;
`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
            bad_frame_reg  <= 1'b0;
`endif
            if (accept) begin
                if (drop_frame_reg) begin
                    // Discarding the tail of an overflowed frame.
                    if (input_axis_tlast) begin
                        drop_frame_reg <= 1'b0;
                        overflow_reg   <= 1'b1;
                    end
                end else if (full) begin
                    // No room: forget everything written for this frame.
                    wr_ptr_cur_reg <= wr_ptr_reg;
                    if (input_axis_tlast) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        drop_frame_reg <= 1'b1;
                    end
                end else begin
                    wr_ptr_cur_reg <= wr_ptr_cur_reg + PTR_ONE;
                    if (input_axis_tlast) begin
`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
                        if (input_axis_tuser) begin
                            wr_ptr_cur_reg <= wr_ptr_reg;
                            bad_frame_reg  <= 1'b1;
                        end else begin
                            wr_ptr_reg     <= wr_ptr_cur_reg + PTR_ONE;
                            good_frame_reg <= 1'b1;
                        end
`else
                        wr_ptr_reg     <= wr_ptr_cur_reg + PTR_ONE;
                        good_frame_reg <= 1'b1;
`endif
                    end
                end
            end
        end
    end

    // Read side: advance the read pointer on each load, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else if (rd_en) begin
            rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
            out_valid_reg <= 1'b1;
        end else if (output_axis_tready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign output_axis_tdata  = rd_rec[DATA_WIDTH-1:0];
    assign output_axis_tkeep  = rd_rec[DATA_WIDTH +: KEEP_WIDTH];
    assign output_axis_tlast  = rd_rec[LAST_IDX];
    assign output_axis_tvalid = out_valid_reg;
    assign overflow           = overflow_reg;
    assign good_frame         = good_frame_reg;

`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
    // Bad frames never reach the output, so tuser is forced low.
    assign output_axis_tuser = rd_rec[USER_IDX] & 1'b0;
    assign bad_frame         = bad_frame_reg;
`else
    assign output_axis_tuser = rd_rec[USER_IDX];
    assign bad_frame         = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Self-checking bench for axis_frame_fifo (small 16-beat instance).
module tb_axis_frame_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef logic [10:0] beat_t;  // {tlast, tuser, tkeep, tdata}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic [0:0] in_keep = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_last = 1'b0;
    logic       in_user = 1'b0;
    logic [7:0] out_data;
    logic [0:0] out_keep;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       out_user;
    logic       overflow;
    logic       bad_frame;
    logic       good_frame;

    int checks = 0;
    int errors = 0;

    axis_frame_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (8),
        .KEEP_WIDTH (1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .input_axis_tdata   (in_data),
        .input_axis_tkeep   (in_keep),
        .input_axis_tvalid  (in_valid),
        .input_axis_tready  (in_ready),
        .input_axis_tlast   (in_last),
        .input_axis_tuser   (in_user),
        .output_axis_tdata  (out_data),
        .output_axis_tkeep  (out_keep),
        .output_axis_tvalid (out_valid),
        .output_axis_tready (out_ready),
        .output_axis_tlast  (out_last),
        .output_axis_tuser  (out_user),
        .overflow           (overflow),
        .bad_frame          (bad_frame),
        .good_frame         (good_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: collects handshaken beats and counts status pulses.
    beat_t rx_q[$];
    int    good_cnt = 0;
    int    bad_cnt = 0;
    int    ovf_cnt = 0;
    int    last_rise = -1;
    logic  valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            valid_prev <= 1'b0;
        end else begin
            if (out_valid && out_ready) rx_q.push_back({out_last, out_user, out_keep, out_data});
            if (good_frame) good_cnt <= good_cnt + 1;
            if (bad_frame)  bad_cnt  <= bad_cnt + 1;
            if (overflow)   ovf_cnt  <= ovf_cnt + 1;
            if (out_valid && !valid_prev) last_rise <= cyc;
            valid_prev <= out_valid;
        end
    end

    // Reference rule: a frame survives only if it fits beside unread data.
    function automatic bit frame_fits(input int occupied, input int len);
        return (occupied + len) <= DEPTH;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u);
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_user  = u;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int base, input int n, input int budget);
        for (int c = 0; c < budget && (rx_q.size() - base) < n; c++) @(negedge clk);
        idle(1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", in_ready); end
        checks++;
        if ({out_valid, out_last, out_user, out_data} !== 11'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {out_valid, out_last, out_user, out_data});
        end
        checks++;
        if ({overflow, bad_frame, good_frame} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {overflow, bad_frame, good_frame});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tready: got %b want 1", in_ready); end
        $display("test_reset done");
        idle(1);
    endtask

    task automatic test_single_frame;
        int base, g0, t_last;
        base = rx_q.size();
        g0 = good_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) t_last = cyc;
            send_beat(8'(i + 1), 1'b1, i == 3, 1'b0);
        end
        wait_rx(base, 4, 40);
        idle(3);
        checks++;
        if (rx_q.size() - base != 4) begin errors++; $display("FAIL single_count: got %0d want 4", rx_q.size() - base); end
        for (int i = 0; i < 4 && base + i < rx_q.size(); i++) begin
            beat_t exp_b;
            exp_b = {i == 3, 1'b0, 1'b1, 8'(i + 1)};
            checks++;
            if (rx_q[base + i] !== exp_b) begin errors++; $display("FAIL single_beat%0d: got %h want %h", i, rx_q[base + i], exp_b); end
        end
        checks++;
        if (last_rise !== t_last + 2) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", last_rise, t_last + 2); end
        checks++;
        if (good_cnt - g0 != 1) begin errors++; $display("FAIL single_good: got %0d want 1", good_cnt - g0); end
        $display("test_single_frame: %0d beats", rx_q.size() - base);
    endtask

    task automatic test_back_to_back;
        int base, gaps;
        logic [7:0] sent[100];
        base = rx_q.size();
        gaps = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    sent[i] = 8'($urandom);
                    send_beat(sent[i], 1'b1, 1'b1, 1'b0);
                end
            end
            begin
                bit seen;
                seen = 0;
                for (int c = 0; c < 400 && (rx_q.size() - base) < 100; c++) begin
                    @(negedge clk);
                    if (seen && !out_valid && (rx_q.size() - base) < 100) gaps++;
                    if (out_valid) seen = 1;
                end
            end
        join
        idle(3);
        checks++;
        if (rx_q.size() - base != 100) begin errors++; $display("FAIL b2b_count: got %0d want 100", rx_q.size() - base); end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
        for (int i = 0; i < 100 && base + i < rx_q.size(); i++) begin
            beat_t exp_b;
            exp_b = {1'b1, 1'b0, 1'b1, sent[i]};
            checks++;
            if (rx_q[base + i] !== exp_b) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, rx_q[base + i], exp_b); end
        end
        $display("test_back_to_back: %0d beats, %0d gaps", rx_q.size() - base, gaps);
    endtask

    task automatic test_overflow;
        int base, g0, o0, occ, exp_ovf, exp_good;
        beat_t exp_q[$];
        int lens[2] = '{10, 10};
        base = rx_q.size();
        g0 = good_cnt;
        o0 = ovf_cnt;
        occ = 0;
        exp_ovf = 0;
        exp_good = 0;
        out_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            bit keep_it;
            keep_it = frame_fits(occ, lens[f]);
            for (int i = 0; i < lens[f]; i++) begin
                logic [7:0] d;
                d = 8'(16 * (f + 1) + i);
                send_beat(d, 1'b1, i == lens[f] - 1, 1'b0);
                if (keep_it) exp_q.push_back({i == lens[f] - 1, 1'b0, 1'b1, d});
            end
            if (keep_it) begin occ += lens[f]; exp_good++; end else exp_ovf++;
        end
        idle(3);
        checks++;
        if (ovf_cnt - o0 != exp_ovf) begin errors++; $display("FAIL ovf_pulses: got %0d want %0d", ovf_cnt - o0, exp_ovf); end
        checks++;
        if (good_cnt - g0 != exp_good) begin errors++; $display("FAIL ovf_good: got %0d want %0d", good_cnt - g0, exp_good); end
        out_ready = 1'b1;
        idle(40);
        checks++;
        if (rx_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL ovf_count: got %0d want %0d", rx_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, rx_q[base + i], exp_q[i]); end
        end
        $display("test_overflow: %0d beats out, %0d overflow pulses", rx_q.size() - base, ovf_cnt - o0);
    endtask

    task automatic test_oversize;
        int base, o0, g0;
        base = rx_q.size();
        o0 = ovf_cnt;
        g0 = good_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_beat(8'(8'h40 + i), 1'b1, i == 19, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(8'(8'h80 + i), 1'b1, i == 2, 1'b0);
        wait_rx(base, 3, 40);
        idle(5);
        checks++;
        if (ovf_cnt - o0 != (frame_fits(0, 20) ? 0 : 1)) begin errors++; $display("FAIL oversize_ovf: got %0d want 1", ovf_cnt - o0); end
        checks++;
        if (good_cnt - g0 != 1) begin errors++; $display("FAIL oversize_good: got %0d want 1", good_cnt - g0); end
        checks++;
        if (rx_q.size() - base != 3) begin errors++; $display("FAIL oversize_count: got %0d want 3", rx_q.size() - base); end
        for (int i = 0; i < 3 && base + i < rx_q.size(); i++) begin
            beat_t exp_b;
            exp_b = {i == 2, 1'b0, 1'b1, 8'(8'h80 + i)};
            checks++;
            if (rx_q[base + i] !== exp_b) begin errors++; $display("FAIL oversize_beat%0d: got %h want %h", i, rx_q[base + i], exp_b); end
        end
        $display("test_oversize: %0d beats after dropped frame", rx_q.size() - base);
    endtask

    task automatic test_bad_frame;
        int base, b0, g0;
        base = rx_q.size();
        b0 = bad_cnt;
        g0 = good_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(8'(8'hB0 + i), 1'b1, i == 2, i == 2);
        idle(20);
`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
        checks++;
        if (rx_q.size() - base != 0) begin errors++; $display("FAIL bad_count: got %0d want 0", rx_q.size() - base); end
        checks++;
        if (bad_cnt - b0 != 1) begin errors++; $display("FAIL bad_pulse: got %0d want 1", bad_cnt - b0); end
        checks++;
        if (good_cnt - g0 != 0) begin errors++; $display("FAIL bad_good: got %0d want 0", good_cnt - g0); end
`else
        checks++;
        if (rx_q.size() - base != 3) begin errors++; $display("FAIL bad_count: got %0d want 3", rx_q.size() - base); end
        for (int i = 0; i < 3 && base + i < rx_q.size(); i++) begin
            beat_t exp_b;
            exp_b = {i == 2, i == 2, 1'b1, 8'(8'hB0 + i)};
            checks++;
            if (rx_q[base + i] !== exp_b) begin errors++; $display("FAIL bad_beat%0d: got %h want %h", i, rx_q[base + i], exp_b); end
        end
        checks++;
        if (bad_cnt - b0 != 0) begin errors++; $display("FAIL bad_pulse: got %0d want 0", bad_cnt - b0); end
        checks++;
        if (good_cnt - g0 != 1) begin errors++; $display("FAIL bad_good: got %0d want 1", good_cnt - g0); end
`endif
        $display("test_bad_frame: %0d beats out, bad pulses %0d", rx_q.size() - base, bad_cnt - b0);
    endtask

    task automatic test_reset_mid_frame;
        int base;
        out_ready = 1'b1;
        send_beat(8'hC0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        send_beat(8'hC1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        base = rx_q.size();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        idle(10);
        checks++;
        if (rx_q.size() - base != 0) begin errors++; $display("FAIL midrst_empty: got %0d beats want 0", rx_q.size() - base); end
        for (int i = 0; i < 5; i++) send_beat(8'(8'hD0 + i), 1'b1, i == 4, 1'b0);
        wait_rx(base, 5, 40);
        idle(3);
        checks++;
        if (rx_q.size() - base != 5) begin errors++; $display("FAIL midrst_count: got %0d want 5", rx_q.size() - base); end
        for (int i = 0; i < 5 && base + i < rx_q.size(); i++) begin
            beat_t exp_b;
            exp_b = {i == 4, 1'b0, 1'b1, 8'(8'hD0 + i)};
            checks++;
            if (rx_q[base + i] !== exp_b) begin errors++; $display("FAIL midrst_beat%0d: got %h want %h", i, rx_q[base + i], exp_b); end
        end
        $display("test_reset_mid_frame: %0d beats after reset", rx_q.size() - base);
    endtask

    task automatic test_random;
        int base, g0, b0, exp_good, exp_bad;
        bit done;
        beat_t exp_q[$];
        base = rx_q.size();
        g0 = good_cnt;
        b0 = bad_cnt;
        exp_good = 0;
        exp_bad = 0;
        done = 0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int len;
                    bit bad, keep_it;
                    len = $urandom_range(1, 8);
                    bad = ($urandom_range(0, 4) == 0);
                    for (int c = 0; c < 200 && (exp_q.size() - (rx_q.size() - base)) + len > DEPTH; c++) idle(1);
`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
                    keep_it = !bad;
`else
                    keep_it = 1;
`endif
                    for (int i = 0; i < len; i++) begin
                        logic [7:0] d;
                        logic k;
                        d = 8'($urandom);
                        k = 1'($urandom);
                        send_beat(d, k, i == len - 1, bad && i == len - 1);
                        if (keep_it) exp_q.push_back({i == len - 1, bad && i == len - 1, k, d});
                    end
                    if (keep_it) exp_good++; else exp_bad++;
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_rx(base, exp_q.size(), 300);
        idle(3);
        checks++;
        if (rx_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", rx_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d: got %h want %h", i, rx_q[base + i], exp_q[i]); end
        end
        checks++;
        if (good_cnt - g0 != exp_good) begin errors++; $display("FAIL rand_good: got %0d want %0d", good_cnt - g0, exp_good); end
`ifdef AXIS_FRAME_FIFO_DROP_BAD_EN
        checks++;
        if (bad_cnt - b0 != exp_bad) begin errors++; $display("FAIL rand_bad: got %0d want %0d", bad_cnt - b0, exp_bad); end
`else
        checks++;
        if (bad_cnt - b0 != 0) begin errors++; $display("FAIL rand_bad: got %0d want 0 (%0d bad frames sent)", bad_cnt - b0, exp_bad); end
`endif
        $display("test_random: %0d beats, %0d good frames", rx_q.size() - base, good_cnt - g0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_oversize();
        test_bad_frame();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
